word_serializer: RTL and testbench

Transmit-side width converter: accepts one WORD_WIDTH-bit word (nonce, hash or header field) on a valid/ready input and emits it as CHUNK_WIDTH-bit chunks, most-significant chunk first, on a valid/ready output. It is the transmit-direction counterpart to the byte-assembling receive path, and it sits between the miner core result registers and the byte-wide UART transmitter. Each chunk is held stable until the downstream side accepts it.

---
 rtl/word_serializer.sv | 131 +++++++++++++
 tb/tb_word_serializer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// word_serializer: splits a WORD_WIDTH-bit word into CHUNK_WIDTH-bit chunks, MSB chunk first.
// Optional SERIALIZER_BACK_TO_BACK_EN loads the next word on the last chunk handshake (no bubble).
module word_serializer #(
  parameter int WORD_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [WORD_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [CHUNK_WIDTH-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int N  = WORD_WIDTH / CHUNK_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state_r, state_s;
  logic [WORD_WIDTH-1:0]  shift_r, shift_s;
  logic [CW-1:0]          cnt_r, cnt_s;
  logic [CHUNK_WIDTH-1:0] out_data_r, out_data_s;
  logic                   out_valid_r, out_valid_s;
  logic                   done_r, done_s;
  logic                   in_ready_s;
  logic                   b2b_take_s;

`ifdef SERIALIZER_BACK_TO_BACK_EN
  assign b2b_take_s = in_valid;
`else
  assign b2b_take_s = 1'b0;
`endif

  // State register: FSM state, datapath and registered outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      shift_r     <= {WORD_WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      out_data_r  <= {CHUNK_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      shift_r     <= shift_s;
      cnt_r       <= cnt_s;
      out_data_r  <= out_data_s;
      out_valid_r <= out_valid_s;
      done_r      <= done_s;
    end
  end

  // Next-state logic: load, shift, and finish a word
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    cnt_s   = cnt_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = SEND;
          shift_s = in_data;
          cnt_s   = CNT_LAST;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (cnt_r != {CW{1'b0}}) begin
            shift_s = {shift_r[WORD_WIDTH-CHUNK_WIDTH-1:0], {CHUNK_WIDTH{1'b0}}};
            cnt_s   = cnt_r - CNT_ONE;
          end else if (b2b_take_s) begin
            done_s  = 1'b1;
            shift_s = in_data;
            cnt_s   = CNT_LAST;
          end else begin
            done_s  = 1'b1;
            state_s = IDLE;
            shift_s = {WORD_WIDTH{1'b0}};
            cnt_s   = {CW{1'b0}};
          end
        end else begin
          state_s = SEND;
        end
      end
      default: begin
        state_s = IDLE;
        shift_s = {WORD_WIDTH{1'b0}};
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // Output logic: ready and the next registered chunk (zeros when idle)
  always_comb begin
    in_ready_s = (state_r == IDLE);
`ifdef SERIALIZER_BACK_TO_BACK_EN
    if ((state_r == SEND) && (cnt_r == {CW{1'b0}}) && out_ready) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = (state_r == IDLE);
    end
`endif
    if (state_s == SEND) begin
      out_valid_s = 1'b1;
      out_data_s  = shift_s[WORD_WIDTH-1 -: CHUNK_WIDTH];
    end else begin
      out_valid_s = 1'b0;
      out_data_s  = {CHUNK_WIDTH{1'b0}};
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign busy      = (state_r == SEND);
  assign done      = done_r;

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer (32-bit words, 8-bit chunks): table vectors,
// directed corner sequences and random traffic against a chunk-queue reference model.
module tb_word_serializer;

`ifdef SERIALIZER_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  localparam int N = 4;

  logic        clock = 1'b0;
  logic        reset_n, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [31:0] in_data;
  logic [7:0]  out_data;

  word_serializer #(.WORD_WIDTH(32), .CHUNK_WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model: pending chunks of the word in flight, plus the done pulse
  logic [7:0] mq[$];
  logic       dm = 1'b0;
  logic       acc;
  // observations
  logic [7:0] got[$];
  int         done_cnt;
  int         first_hs, last_hs;
  logic       s_ov, s_busy, s_done, s_ir;
  logic [7:0] s_od;

  typedef struct packed {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        rn;
    logic        e_ov;
    logic [7:0]  e_od;
    logic        e_busy;
    logic        e_done;
    logic        e_ir;
  } vec_t;
  vec_t vec[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [31:0] id, input logic ordy, input logic rn);
    logic       e_ov, e_ir, hs_o, hs_i;
    logic [7:0] e_od;
    in_valid = iv; in_data = id; out_ready = ordy; reset_n = rn;
    @(negedge clock);
    e_ov = (mq.size() > 0);
    e_od = e_ov ? mq[0] : 8'h00;
    e_ir = (mq.size() == 0) || (B2B && mq.size() == 1 && ordy);
    chk("out_valid", {31'd0, out_valid}, {31'd0, e_ov});
    chk("out_data", {24'd0, out_data}, {24'd0, e_od});
    chk("busy", {31'd0, busy}, {31'd0, e_ov});
    chk("done", {31'd0, done}, {31'd0, dm});
    chk("in_ready", {31'd0, in_ready}, {31'd0, e_ir});
    s_ov = out_valid; s_od = out_data; s_busy = busy; s_done = done; s_ir = in_ready;
    if (rn && out_valid === 1'b1 && ordy) begin
      got.push_back(out_data);
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
    end
    if (done === 1'b1) done_cnt++;
    acc = 1'b0;
    if (!rn) begin
      mq.delete();
      dm = 1'b0;
    end else begin
      hs_o = e_ov && ordy;
      hs_i = iv && e_ir;
      dm   = hs_o && (mq.size() == 1);
      if (hs_o) void'(mq.pop_front());
      if (hs_i) begin
        for (int i = N - 1; i >= 0; i--) mq.push_back(id[i*8 +: 8]);
        acc = 1'b1;
      end
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_obs();
    got.delete();
    done_cnt = 0;
    first_hs = -1;
    last_hs  = -1;
  endtask

  task automatic chk_got(input string name, input logic [31:0] w0, input logic [31:0] w1, input int nw);
    logic [31:0] ws[2];
    ws[0] = w0; ws[1] = w1;
    chk({name, "_count"}, got.size(), nw * N);
    for (int k = 0; k < nw * N && k < got.size(); k++)
      chk({name, "_chunk"}, {24'd0, got[k]}, {24'd0, ws[k / N][(N - 1 - (k % N)) * 8 +: 8]});
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    clear_obs();

    // basic DEADBEEF with out_ready held high
    vec[0] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vec[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 8'hDE, 1'b1, 1'b0, 1'b0};
    vec[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 8'hAD, 1'b1, 1'b0, 1'b0};
    vec[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 8'hBE, 1'b1, 1'b0, 1'b0};
    vec[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 8'hEF, 1'b1, 1'b0, B2B};
    vec[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    vec[6] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    for (int v = 0; v < 7; v++) begin
      step(vec[v].iv, vec[v].id, vec[v].ordy, vec[v].rn);
      chk("tbl_out_valid", {31'd0, s_ov}, {31'd0, vec[v].e_ov});
      chk("tbl_out_data", {24'd0, s_od}, {24'd0, vec[v].e_od});
      chk("tbl_busy", {31'd0, s_busy}, {31'd0, vec[v].e_busy});
      chk("tbl_done", {31'd0, s_done}, {31'd0, vec[v].e_done});
      chk("tbl_in_ready", {31'd0, s_ir}, {31'd0, vec[v].e_ir});
    end

    // backpressure: three stalled cycles before each chunk handshake
    clear_obs();
    step(1'b1, 32'h01234567, 1'b0, 1'b1);
    for (int c = 0; c < N; c++) begin
      repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b1);
    end
    repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1);
    chk_got("bp", 32'h01234567, 32'h0, 1);
    chk("bp_done_cnt", done_cnt, 32'd1);

    // busy protection: second word offered mid-send is ignored
    clear_obs();
    step(1'b1, 32'hCAFEF00D, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h11111111, 1'b1, 1'b1);
    chk("busy_in_ready", {31'd0, s_ir}, 32'd0);
    repeat (5) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk_got("busyprot", 32'hCAFEF00D, 32'h0, 1);
    chk("busyprot_done_cnt", done_cnt, 32'd1);

    // reset after chunk AD of DEADBEEF, then a fresh word
    step(1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    clear_obs();
    step(1'b1, 32'h00000001, 1'b1, 1'b1);
    chk("rst_out_valid", {31'd0, s_ov}, 32'd0);
    chk("rst_busy", {31'd0, s_busy}, 32'd0);
    chk("rst_done", {31'd0, s_done}, 32'd0);
    chk("rst_in_ready", {31'd0, s_ir}, 32'd1);
    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk_got("rst", 32'h00000001, 32'h0, 1);

    // consecutive words with in_valid held high
    clear_obs();
    step(1'b1, 32'hAABBCCDD, 1'b1, 1'b1);
    for (int t = 0; t < 8; t++) begin
      step(1'b1, 32'h11223344, 1'b1, 1'b1);
      if (acc) break;
    end
    repeat (7) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk_got("b2b", 32'hAABBCCDD, 32'h11223344, 2);
    chk("b2b_done_cnt", done_cnt, 32'd2);
    chk("b2b_span", last_hs - first_hs, B2B ? 32'd7 : 32'd8);

    // random traffic against the model
    for (int r = 0; r < 600; r++)
      step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 59) != 0));
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
